// File: rtl/ysyx_2022040010_uncache_ctrl.sv
// Uncached (MMIO) access controller for the LSU data-SRAM path.
// It accepts one uncached load or store at a time and forwards it to the AXI bridge.
// The pipeline is stalled while a blocking access is outstanding.
// Stores may optionally be posted, so the pipeline keeps running while they complete.
// Each access finishes with a one-cycle hit pulse, with err set on a bus error or timeout.
module ysyx_2022040010_uncache_ctrl #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT     = 255,
    parameter int POST_WRITES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uncache,
    input  logic                dsram_e,
    input  logic                dsram_we,
    input  logic [ADDR_W-1:0]   dsram_addr,
    input  logic [DATA_W-1:0]   dsram_wdata,
    input  logic [DATA_W/8-1:0] dsram_sel,
    output logic                stallreq,
    output logic                miss,
    output logic                hit,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                axi_req,
    output logic                axi_we,
    output logic [ADDR_W-1:0]   axi_addr,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_gnt,
    input  logic                refresh,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic                axi_rerr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 16;

    // The counter holds the number of WAIT cycles already spent.
    // The timeout therefore fires on the TIMEOUT-th WAIT cycle.
    // That is the same cycle on which a refresh arriving TIMEOUT cycles after the grant would complete.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic POST_CFG = (POST_WRITES == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_we;
    logic                r_posted;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_uc_access;
    logic                w_accept;
    logic                w_resp;
    logic                w_timeout;
    logic                w_pend_blk;

    assign w_uc_access = uncache & dsram_e;
    assign w_accept    = (r_state == S_IDLE) & w_uc_access;
    assign w_resp      = (r_state == S_WAIT) & refresh;
    assign w_timeout   = (r_state == S_WAIT) & ~refresh & (r_cnt == CNT_LAST);
    assign w_pend_blk  = ~r_posted;

    // State register. Reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    // A refresh seen outside WAIT is a bridge protocol violation and is ignored.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_REQ;
            S_REQ:  if (axi_gnt) w_state_next = S_WAIT;
            S_WAIT: if (w_resp || w_timeout) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stall request.
    // A blocking access holds the pipeline until its DONE cycle.
    // A posted store only stalls a second uncached access, and only until the controller is idle again.
    always_comb begin
        stallreq = 1'b0;
        unique case (r_state)
            S_IDLE:         stallreq = w_uc_access & ~(dsram_we & POST_CFG);
            S_REQ, S_WAIT:  stallreq = w_pend_blk | w_uc_access;
            S_DONE:         stallreq = ~w_pend_blk & w_uc_access;
            default:        stallreq = 1'b0;
        endcase
    end

    // Request latch.
    // The access is captured only on acceptance in IDLE.
    // An access the pipeline keeps presenting while stalled is therefore never captured twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_we     <= 1'b0;
            r_posted <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= dsram_addr;
            r_wdata  <= dsram_wdata;
            r_wstrb  <= dsram_sel;
            r_we     <= dsram_we;
            r_posted <= dsram_we & POST_CFG;
        end
    end

    // Wait-cycle counter: cleared at the grant, then counting every cycle spent in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) && axi_gnt) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Response capture.
    // A real response takes priority over a timeout on the same cycle.
    // Only loads touch the read-data register, so a store leaves the last load data visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_resp) begin
            if (!r_we) begin
                r_rdata <= axi_rdata;
            end
            r_err <= axi_rerr;
        end else if (w_timeout) begin
            if (!r_we) begin
                r_rdata <= '0;
            end
            r_err <= 1'b1;
        end
    end

    assign miss      = uncache;
    assign hit       = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) & r_err;
    assign rdata     = r_rdata;
    assign axi_req   = (r_state == S_REQ);
    assign axi_we    = r_we;
    assign axi_addr  = r_addr;
    assign axi_wdata = r_wdata;
    assign axi_wstrb = r_wstrb;

endmodule

// File: tb/tb_ysyx_2022040010_uncache_ctrl.sv
// Directed bench for the uncached access controller.
// A transaction-level model tracks each outstanding access and is compared against the DUT every cycle.
// Literal checks in the stimulus pin the key timings and values.
module tb_ysyx_2022040010_uncache_ctrl;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_POST    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uncache = 1'b0;
    logic        dsramE = 1'b0;
    logic        dsramWe = 1'b0;
    logic [63:0] dsramAddr = '0;
    logic [63:0] dsramWdata = '0;
    logic [7:0]  dsramSel = '0;
    logic        axiGnt = 1'b0;
    logic        refresh = 1'b0;
    logic [63:0] axiRdataIn = '0;
    logic        axiRerr = 1'b0;

    logic        stallreq;
    logic        miss;
    logic        hit;
    logic        err;
    logic [63:0] rdata;
    logic        axiReq;
    logic        axiWe;
    logic [63:0] axiAddr;
    logic [63:0] axiWdata;
    logic [7:0]  axiWstrb;

    int assertCount = 0;
    int failCount   = 0;

    ysyx_2022040010_uncache_ctrl #(
        .ADDR_W(64),
        .DATA_W(64),
        .TIMEOUT(TB_TIMEOUT),
        .POST_WRITES(TB_POST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uncache(uncache),
        .dsram_e(dsramE),
        .dsram_we(dsramWe),
        .dsram_addr(dsramAddr),
        .dsram_wdata(dsramWdata),
        .dsram_sel(dsramSel),
        .stallreq(stallreq),
        .miss(miss),
        .hit(hit),
        .err(err),
        .rdata(rdata),
        .axi_req(axiReq),
        .axi_we(axiWe),
        .axi_addr(axiAddr),
        .axi_wdata(axiWdata),
        .axi_wstrb(axiWstrb),
        .axi_gnt(axiGnt),
        .refresh(refresh),
        .axi_rdata(axiRdataIn),
        .axi_rerr(axiRerr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then return at the falling edge.
    task automatic applyStimulus(input logic rstIn, input logic uc, input logic e, input logic we,
                                 input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] sel,
                                 input logic gnt, input logic rfr, input logic [63:0] rd, input logic rerr);
        @(posedge clk);
        #1;
        rst        = rstIn;
        uncache    = uc;
        dsramE     = e;
        dsramWe    = we;
        dsramAddr  = addr;
        dsramWdata = wd;
        dsramSel   = sel;
        axiGnt     = gnt;
        refresh    = rfr;
        axiRdataIn = rd;
        axiRerr    = rerr;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    // Transaction model.
    // mBusy means an access has been accepted but has not completed yet.
    // mGranted means the bridge has taken that access.
    // mHit marks the single completion cycle.
    bit          modelValid = 1'b0;
    bit          mBusy = 1'b0;
    bit          mGranted = 1'b0;
    bit          mHit = 1'b0;
    bit          mErr = 1'b0;
    bit          mWe = 1'b0;
    bit          mPosted = 1'b0;
    int          mWaited = 0;
    logic [63:0] mAddr = '0;
    logic [63:0] mWdata = '0;
    logic [7:0]  mSel = '0;
    logic [63:0] mRdata = '0;

    // Compare against the model on every falling edge, then advance the model with this cycle's inputs.
    initial begin
        logic expStall;
        bit   done;
        forever begin
            @(negedge clk);
            if (modelValid) begin
                if (mBusy)
                    expStall = !mPosted ? 1'b1 : (uncache & dsramE);
                else if (mHit)
                    expStall = !mPosted ? 1'b0 : (uncache & dsramE);
                else
                    expStall = uncache & dsramE & ~(dsramWe & (TB_POST == 1));
                checkOutput("cmp_stallreq", {63'b0, stallreq}, {63'b0, expStall});
                checkOutput("cmp_miss",     {63'b0, miss},     {63'b0, uncache});
                checkOutput("cmp_hit",      {63'b0, hit},      {63'b0, mHit});
                checkOutput("cmp_err",      {63'b0, err},      {63'b0, mHit & mErr});
                checkOutput("cmp_axi_req",  {63'b0, axiReq},   {63'b0, mBusy & !mGranted});
                checkOutput("cmp_rdata",    rdata,             mRdata);
                if (mBusy && !mGranted) begin
                    checkOutput("cmp_axi_we",    {63'b0, axiWe}, {63'b0, mWe});
                    checkOutput("cmp_axi_addr",  axiAddr,        mAddr);
                    checkOutput("cmp_axi_wdata", axiWdata,       mWdata);
                    checkOutput("cmp_axi_wstrb", {56'b0, axiWstrb}, {56'b0, mSel});
                end
            end
            if (rst) begin
                mBusy = 0; mGranted = 0; mHit = 0; mErr = 0; mWe = 0; mPosted = 0; mWaited = 0;
                mAddr = '0; mWdata = '0; mSel = '0; mRdata = '0;
                modelValid = 1'b1;
            end else begin
                done = 1'b0;
                if (mHit) begin
                    done = 1'b0;
                end else if (!mBusy) begin
                    if (uncache && dsramE) begin
                        mBusy = 1; mGranted = 0;
                        mWe = dsramWe; mPosted = dsramWe && (TB_POST == 1);
                        mAddr = dsramAddr; mWdata = dsramWdata; mSel = dsramSel;
                    end
                end else if (!mGranted) begin
                    if (axiGnt) begin
                        mGranted = 1; mWaited = 0;
                    end
                end else begin
                    mWaited++;
                    if (refresh) begin
                        if (!mWe) mRdata = axiRdataIn;
                        mErr = axiRerr;
                        done = 1'b1;
                    end else if (mWaited == TB_TIMEOUT) begin
                        if (!mWe) mRdata = '0;
                        mErr = 1'b1;
                        done = 1'b1;
                    end
                end
                if (done) begin
                    mBusy = 0; mGranted = 0;
                end
                mHit = done;
            end
        end
    end

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        logic [63:0] a1, d1, sAddr, sData, lAddr, d2, tAddr, eAddr, dE, d4, rAddr;
        a1 = 64'hA000_0048; d1 = 64'h1122_3344_5566_7788;
        sAddr = 64'hA000_0000; sData = 64'hDEAD_BEEF_0BAD_F00D;
        lAddr = 64'hA000_0010; d2 = 64'hCAFE_F00D_1234_5678;
        tAddr = 64'hA000_0100; eAddr = 64'hA000_0200; dE = 64'h5555_AAAA_5555_AAAA;
        d4 = 64'h0123_4567_89AB_CDEF; rAddr = 64'hA000_0300;

        // Reset
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        idleCycle();
        checkOutput("rst_stallreq", {63'b0, stallreq}, 64'd0);
        checkOutput("rst_hit",      {63'b0, hit},      64'd0);
        checkOutput("rst_err",      {63'b0, err},      64'd0);
        checkOutput("rst_axi_req",  {63'b0, axiReq},   64'd0);
        checkOutput("rst_axi_we",   {63'b0, axiWe},    64'd0);
        checkOutput("rst_rdata",    rdata,             64'd0);
        checkOutput("rst_axi_addr", axiAddr,           64'd0);

        // 1: uncached load, grant on first REQ cycle, refresh 3 cycles after the grant
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a1, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t1_accept_stall", {63'b0, stallreq}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a1, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        checkOutput("t1_axi_req",  {63'b0, axiReq}, 64'd1);
        checkOutput("t1_axi_addr", axiAddr,         64'hA000_0048);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a1, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a1, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t1_wait_stall", {63'b0, stallreq}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a1, 64'h0, 8'hFF, 1'b0, 1'b1, d1, 1'b0);
        checkOutput("t1_refresh_stall", {63'b0, stallreq}, 64'd1);
        checkOutput("t1_refresh_nohit", {63'b0, hit},      64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a1, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t1_hit",       {63'b0, hit},      64'd1);
        checkOutput("t1_err",       {63'b0, err},      64'd0);
        checkOutput("t1_rdata",     rdata,             64'h1122_3344_5566_7788);
        checkOutput("t1_hit_stall", {63'b0, stallreq}, 64'd0);
        idleCycle();
        checkOutput("t1_single_hit", {63'b0, hit}, 64'd0);
        checkOutput("t1_rdata_held", rdata,        64'h1122_3344_5566_7788);

        // 2: posted store, followed immediately by an uncached load
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, sAddr, sData, 8'h0F, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_store_nostall", {63'b0, stallreq}, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, lAddr, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_store_req",   {63'b0, axiReq}, 64'd1);
        checkOutput("t2_store_we",    {63'b0, axiWe},  64'd1);
        checkOutput("t2_store_wstrb", {56'b0, axiWstrb}, 64'h0F);
        checkOutput("t2_store_wdata", axiWdata, 64'hDEAD_BEEF_0BAD_F00D);
        checkOutput("t2_load_stall",  {63'b0, stallreq}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, lAddr, 64'h0, 8'hFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, lAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_store_hit",   {63'b0, hit},      64'd1);
        checkOutput("t2_done_stall",  {63'b0, stallreq}, 64'd1);
        checkOutput("t2_store_rdata", rdata,             64'h1122_3344_5566_7788);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, lAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_load_accept_stall", {63'b0, stallreq}, 64'd1);
        checkOutput("t2_idle_noreq",        {63'b0, axiReq},   64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, lAddr, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_load_we",   {63'b0, axiWe}, 64'd0);
        checkOutput("t2_load_addr", axiAddr,        64'hA000_0010);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, lAddr, 64'h0, 8'hFF, 1'b0, 1'b1, d2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, lAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_load_hit",   {63'b0, hit},      64'd1);
        checkOutput("t2_load_rdata", rdata,             64'hCAFE_F00D_1234_5678);
        checkOutput("t2_load_stall_off", {63'b0, stallreq}, 64'd0);
        idleCycle();

        // 3: load with no response; the timeout completes it
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, tAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, tAddr, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, tAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        end
        checkOutput("t3_last_wait_nohit", {63'b0, hit},      64'd0);
        checkOutput("t3_last_wait_stall", {63'b0, stallreq}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, tAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t3_timeout_hit",   {63'b0, hit}, 64'd1);
        checkOutput("t3_timeout_err",   {63'b0, err}, 64'd1);
        checkOutput("t3_timeout_rdata", rdata,        64'd0);
        idleCycle();
        checkOutput("t3_back_idle", {63'b0, axiReq}, 64'd0);

        // 4a: a refresh during REQ is ignored, the grant comes late, then an error response
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h99, 1'b0);
        checkOutput("t4_req_hold", {63'b0, axiReq}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b1, dE, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t4_rerr_hit",   {63'b0, hit}, 64'd1);
        checkOutput("t4_rerr_err",   {63'b0, err}, 64'd1);
        checkOutput("t4_rerr_rdata", rdata,        64'h5555_AAAA_5555_AAAA);
        idleCycle();

        // 4b: refresh arrives on exactly the timeout cycle, so the access completes normally
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b1, d4, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, eAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("t4_edge_hit",   {63'b0, hit}, 64'd1);
        checkOutput("t4_edge_err",   {63'b0, err}, 64'd0);
        checkOutput("t4_edge_rdata", rdata,        64'h0123_4567_89AB_CDEF);
        idleCycle();

        // 5: reset while in WAIT; a refresh arriving afterwards must be ignored
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, rAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, rAddr, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, rAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, rAddr, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b1, 64'h77, 1'b1);
        checkOutput("t5_stallreq", {63'b0, stallreq}, 64'd0);
        checkOutput("t5_hit",      {63'b0, hit},      64'd0);
        checkOutput("t5_axi_req",  {63'b0, axiReq},   64'd0);
        checkOutput("t5_rdata",    rdata,             64'd0);
        checkOutput("t5_axi_addr", axiAddr,           64'd0);
        idleCycle();
        checkOutput("t5_no_late_hit", {63'b0, hit},    64'd0);
        checkOutput("t5_no_late_err", {63'b0, err},    64'd0);
        checkOutput("t5_stay_idle",   {63'b0, axiReq}, 64'd0);

        // 6: stream of cached accesses; these are never latched and never stall
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, i[0], 64'h8000_0000 + 64'(i * 8), 64'(i), 8'hFF,
                          1'b1, (i == 3), 64'hABCD, 1'b0);
            checkOutput("t6_stallreq", {63'b0, stallreq}, 64'd0);
            checkOutput("t6_axi_req",  {63'b0, axiReq},   64'd0);
            checkOutput("t6_miss",     {63'b0, miss},     64'd0);
        end
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
